multichannel_spike_binner: RTL and testbench

Parametrised multi-channel spike binner between the per-channel spike detectors and the velocity decoder. Gates spikes during a start-up warmup, counts accepted spikes per channel over a fixed-length bin with saturation, and closes every bin on a common boundary. It then streams each closed frame to the decoder as NUM_CH valid/ready beats, with drop accounting when the decoder falls behind.

---
 rtl/neural_pkg.sv | 17 +
 rtl/spike_bin_ctr.sv | 37 +++
 rtl/multichannel_spike_binner.sv | 166 ++++++++++++++++
 tb/tb_multichannel_spike_binner.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_pkg.sv
// Shared defaults and FSM encoding for the neural spike binning path.
// Consumed by the spike binner top and its per-channel accumulators.
package neural_pkg;

    localparam int unsigned DEF_NUM_CH     = 8;
    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_BIN_LEN    = 1500;
    localparam int unsigned DEF_WARMUP_CYC = 150000;
    localparam int unsigned FRAME_IDX_W    = 16;
    localparam int unsigned DROP_CNT_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } bin_state_t;

endpackage

// File: rtl/spike_bin_ctr.sv
// Per-channel saturating spike accumulator.
// closed_c is the value the bin would close with this cycle, including this cycle's spike.
module spike_bin_ctr
    import neural_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic             close,
    output logic [CNT_W-1:0] closed_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] acc;

    always_comb begin
        closed_c = acc;
        if (accept && (acc != CNT_MAX)) begin
            closed_c = acc + 1'b1;
        end
    end

    // A closing boundary hands closed_c to the top and restarts the bin from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (close) begin
            acc <= '0;
        end else begin
            acc <= closed_c;
        end
    end

endmodule

// File: rtl/multichannel_spike_binner.sv
// Bins gated spikes per channel over fixed-length windows and streams each closed
// frame as NUM_CH valid/ready beats, dropping new bins while a frame is still draining.
module multichannel_spike_binner
    import neural_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned BIN_LEN    = DEF_BIN_LEN,
    parameter int unsigned WARMUP_CYC = DEF_WARMUP_CYC,
    parameter int unsigned CH_W       = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      spike_in,
    input  logic [NUM_CH-1:0]      ch_en,
    output logic                   warm_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_last,
    output logic [FRAME_IDX_W-1:0] bin_idx,
    output logic                   overrun,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int unsigned BIN_W     = $clog2(BIN_LEN);
    localparam int unsigned WU_W      = $clog2(WARMUP_CYC + 2);
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(BIN_LEN - 1);
    localparam logic [WU_W-1:0]  WU_TGT   = WU_W'(WARMUP_CYC);
    localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(NUM_CH - 1);

    logic [WU_W-1:0]   wu_cnt;
    logic [WU_W-1:0]   wu_next;
    logic [BIN_W-1:0]  timer;
    logic              boundary;
    logic              warm_bnd;
    logic              hs;
    logic [NUM_CH-1:0] accept;
    logic [CNT_W-1:0]  closed [NUM_CH];
    logic [CNT_W-1:0]  shadow [NUM_CH];

    bin_state_t        state;
    bin_state_t        state_n;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ptr_n;
    logic              load;
    logic              frame_done;
    logic              drop;

    assign boundary = (timer == BIN_LAST);
    assign warm_bnd = boundary && warm_done;
    assign hs       = out_valid && out_ready;
    assign accept   = spike_in & ch_en & {NUM_CH{warm_done}};
    assign out_ch   = ptr;

    // Warmup saturates at its target; the bin timer free-runs regardless of warmup.
    always_comb begin
        wu_next = wu_cnt;
        if (wu_cnt != WU_TGT) begin
            wu_next = wu_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wu_cnt    <= '0;
            warm_done <= 1'b0;
            timer     <= '0;
        end else begin
            wu_cnt    <= wu_next;
            warm_done <= (wu_next == WU_TGT);
            timer     <= (timer == BIN_LAST) ? '0 : timer + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_bin_ctr #(
            .CNT_W (CNT_W)
        ) u_ctr (
            .clk      (clk),
            .rst_n    (rst_n),
            .accept   (accept[g]),
            .close    (boundary),
            .closed_c (closed[g])
        );
    end

    // Frame sequencer: a final handshake coinciding with a warm boundary chains straight into the next frame.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        load       = 1'b0;
        frame_done = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (warm_bnd) begin
                    load    = 1'b1;
                    ptr_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (hs && (ptr == PTR_LAST)) begin
                    frame_done = 1'b1;
                    ptr_n      = '0;
                    if (warm_bnd) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (hs) begin
                        ptr_n = ptr + 1'b1;
                    end
                    drop = warm_bnd;
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_last  <= 1'b0;
            bin_idx   <= '0;
            overrun   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            out_valid <= (state_n == SEND);
            out_count <= load ? closed[0] : shadow[ptr_n];
            out_last  <= (state_n == SEND) && (ptr_n == PTR_LAST);
            overrun   <= drop;
            if (frame_done) begin
                bin_idx <= bin_idx + 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Shadow bank holds the frame being streamed; dropped bins never touch it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= closed[i];
            end
        end
    end

endmodule

// File: tb/tb_multichannel_spike_binner.sv
// Bench for multichannel_spike_binner: a 4-channel instance (8-bit counts) and a 3-bit
// count instance, short warmup and bins, scoreboarded frame beats plus directed checks.
module tb_multichannel_spike_binner;

    localparam int NCH  = 4;
    localparam int BLEN = 16;
    localparam int WARM = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  spike_a, en_a, spike_b, en_b;
    logic        ready_a, ready_b;
    logic        warm_a, valid_a, last_a, ovr_a;
    logic [1:0]  ch_a;
    logic [7:0]  cnt_a;
    logic [15:0] bin_a, drop_a;
    logic        warm_b, valid_b, last_b, ovr_b;
    logic [1:0]  ch_b;
    logic [2:0]  cnt_b;
    logic [15:0] bin_b, drop_b;

    int checks   = 0;
    int failures = 0;
    int cyc;

    typedef struct {
        int ch;
        int cnt;
        int bin;
    } beat_t;

    beat_t exp_q[$];
    int    m_acc[NCH];
    int    m_bin;

    always #5 clk = ~clk;

    multichannel_spike_binner #(
        .NUM_CH(NCH), .CNT_W(8), .BIN_LEN(BLEN), .WARMUP_CYC(WARM)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_a), .ch_en(en_a),
        .warm_done(warm_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_ch(ch_a), .out_count(cnt_a), .out_last(last_a),
        .bin_idx(bin_a), .overrun(ovr_a), .drop_cnt(drop_a)
    );

    multichannel_spike_binner #(
        .NUM_CH(NCH), .CNT_W(3), .BIN_LEN(BLEN), .WARMUP_CYC(WARM)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_b), .ch_en(en_b),
        .warm_done(warm_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_ch(ch_b), .out_count(cnt_b), .out_last(last_b),
        .bin_idx(bin_b), .overrun(ovr_b), .drop_cnt(drop_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 0 after reset release (timer 0, warmup counter 0).
    task automatic do_reset();
        rst_n   = 1'b0;
        spike_a = 4'h0;
        spike_b = 4'h0;
        en_a    = 4'hF;
        en_b    = 4'hF;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        exp_q.delete();
        m_bin = 0;
        for (int i = 0; i < NCH; i++) m_acc[i] = 0;
    endtask

    // Reference bin accounting for one cycle of accepted-candidate spikes.
    task automatic model_cycle(input logic [3:0] cand, input int maxv);
        for (int i = 0; i < NCH; i++) begin
            if (cand[i] && cyc >= WARM && m_acc[i] < maxv) m_acc[i]++;
        end
        if (cyc % BLEN == BLEN - 1) begin
            if (cyc >= WARM) begin
                for (int i = 0; i < NCH; i++) exp_q.push_back('{i, m_acc[i], m_bin});
                m_bin++;
            end
            for (int i = 0; i < NCH; i++) m_acc[i] = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({warm_a, valid_a, ch_a, cnt_a, last_a, ovr_a} !== 13'd0) begin
            failures++;
            $display("FAIL reset_a_flags: got warm=%0b valid=%0b ch=%0d cnt=%0d last=%0b ovr=%0b, need all 0",
                     warm_a, valid_a, ch_a, cnt_a, last_a, ovr_a);
        end
        checks++;
        if (bin_a !== 16'd0 || drop_a !== 16'd0) begin
            failures++;
            $display("FAIL reset_a_counters: got bin=%0d drop=%0d, need 0 0", bin_a, drop_a);
        end
        checks++;
        if ({warm_b, valid_b, ch_b, cnt_b, last_b, ovr_b} !== 8'd0 || bin_b !== 16'd0 || drop_b !== 16'd0) begin
            failures++;
            $display("FAIL reset_b: got valid=%0b cnt=%0d bin=%0d drop=%0d, need 0", valid_b, cnt_b, bin_b, drop_b);
        end
    endtask

    task automatic test_warmup_full_bins();
        beat_t e;
        do_reset();
        for (int k = 0; k < 56; k++) begin
            spike_a = 4'hF;
            model_cycle(spike_a & en_a, 255);
            checks++;
            if (warm_a !== (cyc >= WARM)) begin
                failures++;
                $display("FAIL warm_done cyc=%0d: got %0b need %0b", cyc, warm_a, cyc >= WARM);
            end
            if (cyc < WARM) begin
                checks++;
                if (valid_a !== 1'b0) begin
                    failures++;
                    $display("FAIL beat_before_warm cyc=%0d: got valid=%0b need 0", cyc, valid_a);
                end
            end
            if (cyc == 32 || cyc == 48) begin
                checks++;
                if (valid_a !== 1'b1 || ch_a !== 2'd0 || cnt_a !== ((cyc == 32) ? 8'd12 : 8'd16)) begin
                    failures++;
                    $display("FAIL frame_start cyc=%0d: got valid=%0b ch=%0d cnt=%0d need 1 0 %0d",
                             cyc, valid_a, ch_a, cnt_a, (cyc == 32) ? 12 : 16);
                end
            end
            if (valid_a && ready_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra cyc=%0d: got ch=%0d cnt=%0d, need no beat", cyc, ch_a, cnt_a);
                end else begin
                    e = exp_q.pop_front();
                    if (ch_a !== 2'(e.ch) || cnt_a !== 8'(e.cnt) || last_a !== (e.ch == NCH - 1) || bin_a !== 16'(e.bin)) begin
                        failures++;
                        $display("FAIL beat_full cyc=%0d: got ch=%0d cnt=%0d last=%0b bin=%0d need ch=%0d cnt=%0d bin=%0d",
                                 cyc, ch_a, cnt_a, last_a, bin_a, e.ch, e.cnt, e.bin);
                    end
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_bins_drain: got %0d beats outstanding need 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        beat_t e;
        do_reset();
        for (int k = 0; k < 70; k++) begin
            spike_b = (cyc >= 32 && cyc <= 47) ? 4'b0001 : 4'b0000;
            model_cycle(spike_b & en_b, 7);
            if (cyc == 48 || cyc == 64) begin
                checks++;
                if (valid_b !== 1'b1 || ch_b !== 2'd0 || cnt_b !== ((cyc == 48) ? 3'd7 : 3'd0)) begin
                    failures++;
                    $display("FAIL sat_ch0 cyc=%0d: got valid=%0b ch=%0d cnt=%0d need 1 0 %0d",
                             cyc, valid_b, ch_b, cnt_b, (cyc == 48) ? 7 : 0);
                end
            end
            if (valid_b && ready_b) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra_b cyc=%0d: got ch=%0d cnt=%0d, need no beat", cyc, ch_b, cnt_b);
                end else begin
                    e = exp_q.pop_front();
                    if (ch_b !== 2'(e.ch) || cnt_b !== 3'(e.cnt) || last_b !== (e.ch == NCH - 1) || bin_b !== 16'(e.bin)) begin
                        failures++;
                        $display("FAIL beat_sat cyc=%0d: got ch=%0d cnt=%0d last=%0b bin=%0d need ch=%0d cnt=%0d bin=%0d",
                                 cyc, ch_b, cnt_b, last_b, bin_b, e.ch, e.cnt, e.bin);
                    end
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sat_drain: got %0d beats outstanding need 0", exp_q.size());
        end
    endtask

    task automatic test_boundary_spike();
        beat_t e;
        do_reset();
        for (int k = 0; k < 70; k++) begin
            spike_a = (cyc == 47) ? 4'b0100 : 4'b0000;
            model_cycle(spike_a & en_a, 255);
            if (cyc == 50 || cyc == 66) begin
                checks++;
                if (ch_a !== 2'd2 || cnt_a !== ((cyc == 50) ? 8'd1 : 8'd0)) begin
                    failures++;
                    $display("FAIL boundary_spike cyc=%0d: got ch=%0d cnt=%0d need 2 %0d",
                             cyc, ch_a, cnt_a, (cyc == 50) ? 1 : 0);
                end
            end
            if (valid_a && ready_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra cyc=%0d: got ch=%0d cnt=%0d, need no beat", cyc, ch_a, cnt_a);
                end else begin
                    e = exp_q.pop_front();
                    if (ch_a !== 2'(e.ch) || cnt_a !== 8'(e.cnt) || last_a !== (e.ch == NCH - 1) || bin_a !== 16'(e.bin)) begin
                        failures++;
                        $display("FAIL beat_bnd cyc=%0d: got ch=%0d cnt=%0d last=%0b bin=%0d need ch=%0d cnt=%0d bin=%0d",
                                 cyc, ch_a, cnt_a, last_a, bin_a, e.ch, e.cnt, e.bin);
                    end
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL boundary_drain: got %0d beats outstanding need 0", exp_q.size());
        end
    endtask

    // Frame from the bin closing at 31 stalls through the boundaries at 47 and 63.
    task automatic test_overrun();
        beat_t e;
        do_reset();
        for (int k = 0; k < 86; k++) begin
            spike_a = (cyc < 32) ? 4'b0011 : ((cyc < 64) ? 4'b1000 : 4'b0000);
            ready_a = (cyc < 32 || cyc >= 64);
            if (cyc == 31) begin
                exp_q.push_back('{0, 12, 0});
                exp_q.push_back('{1, 12, 0});
                exp_q.push_back('{2, 0, 0});
                exp_q.push_back('{3, 0, 0});
            end
            if (cyc == 79) begin
                for (int i = 0; i < NCH; i++) exp_q.push_back('{i, 0, 1});
            end
            checks++;
            if (ovr_a !== (cyc == 48 || cyc == 64)) begin
                failures++;
                $display("FAIL overrun_pulse cyc=%0d: got %0b need %0b", cyc, ovr_a, cyc == 48 || cyc == 64);
            end
            if (cyc >= 32 && cyc < 64) begin
                checks++;
                if (valid_a !== 1'b1 || ch_a !== 2'd0 || cnt_a !== 8'd12 || bin_a !== 16'd0) begin
                    failures++;
                    $display("FAIL stall_stable cyc=%0d: got valid=%0b ch=%0d cnt=%0d bin=%0d need 1 0 12 0",
                             cyc, valid_a, ch_a, cnt_a, bin_a);
                end
            end
            if (cyc == 68) begin
                checks++;
                if (bin_a !== 16'd1 || drop_a !== 16'd2 || valid_a !== 1'b0) begin
                    failures++;
                    $display("FAIL after_drain: got bin=%0d drop=%0d valid=%0b need 1 2 0", bin_a, drop_a, valid_a);
                end
            end
            if (valid_a && ready_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra cyc=%0d: got ch=%0d cnt=%0d, need no beat", cyc, ch_a, cnt_a);
                end else begin
                    e = exp_q.pop_front();
                    if (ch_a !== 2'(e.ch) || cnt_a !== 8'(e.cnt) || last_a !== (e.ch == NCH - 1) || bin_a !== 16'(e.bin)) begin
                        failures++;
                        $display("FAIL beat_ovr cyc=%0d: got ch=%0d cnt=%0d last=%0b bin=%0d need ch=%0d cnt=%0d bin=%0d",
                                 cyc, ch_a, cnt_a, last_a, bin_a, e.ch, e.cnt, e.bin);
                    end
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || drop_a !== 16'd2) begin
            failures++;
            $display("FAIL overrun_end: got %0d beats outstanding drop=%0d need 0 2", exp_q.size(), drop_a);
        end
    endtask

    // Final handshake of frame 0 lands on the boundary at cycle 47.
    task automatic test_back_to_back();
        beat_t e;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            spike_a = (cyc < 32) ? 4'b0100 : ((cyc <= 47) ? 4'b1000 : 4'b0000);
            ready_a = !(cyc >= 32 && cyc < 44);
            model_cycle(spike_a & en_a, 255);
            checks++;
            if (ovr_a !== 1'b0) begin
                failures++;
                $display("FAIL b2b_overrun cyc=%0d: got %0b need 0", cyc, ovr_a);
            end
            if (cyc == 47) begin
                checks++;
                if (valid_a !== 1'b1 || ch_a !== 2'd3 || last_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_final: got valid=%0b ch=%0d last=%0b need 1 3 1", valid_a, ch_a, last_a);
                end
            end
            if (cyc == 48) begin
                checks++;
                if (valid_a !== 1'b1 || ch_a !== 2'd0 || bin_a !== 16'd1 || cnt_a !== 8'd0) begin
                    failures++;
                    $display("FAIL b2b_next: got valid=%0b ch=%0d bin=%0d cnt=%0d need 1 0 1 0",
                             valid_a, ch_a, bin_a, cnt_a);
                end
            end
            if (valid_a && ready_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra cyc=%0d: got ch=%0d cnt=%0d, need no beat", cyc, ch_a, cnt_a);
                end else begin
                    e = exp_q.pop_front();
                    if (ch_a !== 2'(e.ch) || cnt_a !== 8'(e.cnt) || last_a !== (e.ch == NCH - 1) || bin_a !== 16'(e.bin)) begin
                        failures++;
                        $display("FAIL beat_b2b cyc=%0d: got ch=%0d cnt=%0d last=%0b bin=%0d need ch=%0d cnt=%0d bin=%0d",
                                 cyc, ch_a, cnt_a, last_a, bin_a, e.ch, e.cnt, e.bin);
                    end
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || drop_a !== 16'd0) begin
            failures++;
            $display("FAIL b2b_end: got %0d beats outstanding drop=%0d need 0 0", exp_q.size(), drop_a);
        end
    endtask

    // Channel 1 masked off; reset pulse lands mid-way through the second frame.
    task automatic test_disable_and_reset();
        beat_t e;
        do_reset();
        en_a = 4'b1101;
        for (int k = 0; k < 51; k++) begin
            spike_a = 4'hF;
            ready_a = (cyc != 50);
            model_cycle(spike_a & en_a, 255);
            if (cyc == 49) begin
                checks++;
                if (ch_a !== 2'd1 || cnt_a !== 8'd0 || bin_a !== 16'd1) begin
                    failures++;
                    $display("FAIL ch1_disabled: got ch=%0d cnt=%0d bin=%0d need 1 0 1", ch_a, cnt_a, bin_a);
                end
            end
            if (cyc == 50) begin
                checks++;
                if (warm_a !== 1'b1 || valid_a !== 1'b1) begin
                    failures++;
                    $display("FAIL pre_reset: got warm=%0b valid=%0b need 1 1", warm_a, valid_a);
                end
                rst_n = 1'b0;
            end
            if (valid_a && ready_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra cyc=%0d: got ch=%0d cnt=%0d, need no beat", cyc, ch_a, cnt_a);
                end else begin
                    e = exp_q.pop_front();
                    if (ch_a !== 2'(e.ch) || cnt_a !== 8'(e.cnt) || last_a !== (e.ch == NCH - 1) || bin_a !== 16'(e.bin)) begin
                        failures++;
                        $display("FAIL beat_en cyc=%0d: got ch=%0d cnt=%0d last=%0b bin=%0d need ch=%0d cnt=%0d bin=%0d",
                                 cyc, ch_a, cnt_a, last_a, bin_a, e.ch, e.cnt, e.bin);
                    end
                end
            end
            tick();
        end
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if ({warm_a, valid_a, ch_a, cnt_a, last_a, ovr_a} !== 13'd0 || bin_a !== 16'd0 || drop_a !== 16'd0) begin
            failures++;
            $display("FAIL mid_frame_reset: got warm=%0b valid=%0b ch=%0d cnt=%0d last=%0b bin=%0d drop=%0d need all 0",
                     warm_a, valid_a, ch_a, cnt_a, last_a, bin_a, drop_a);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (warm_a !== 1'b0 || valid_a !== 1'b0) begin
                failures++;
                $display("FAIL rewarm: got warm=%0b valid=%0b need 0 0", warm_a, valid_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup_full_bins();
        test_saturation();
        test_boundary_spike();
        test_overrun();
        test_back_to_back();
        test_disable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
